// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package mem_port_arbiter_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned MASK_W = 4;

    localparam logic [MASK_W-1:0] MASK_ALL = 4'hF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        RESP   = 2'd3
    } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, load/store and memory-side signals seen by the arbiter.
interface mem_port_arbiter_if;
    import mem_port_arbiter_pkg::*;

    logic              i_req_in;
    logic [XLEN-1:0]   i_addr_in;
    logic              i_ack_out;
    logic [XLEN-1:0]   i_rdata_out;

    logic              d_req_in;
    logic              d_wr_in;
    logic [XLEN-1:0]   d_addr_in;
    logic [XLEN-1:0]   d_wdata_in;
    logic [MASK_W-1:0] d_mask_in;
    logic              d_ack_out;
    logic [XLEN-1:0]   d_rdata_out;

    logic              err_out;

    logic              mem_req_out;
    logic              mem_wr_out;
    logic [XLEN-1:0]   mem_addr_out;
    logic [XLEN-1:0]   mem_wdata_out;
    logic [MASK_W-1:0] mem_mask_out;
    logic              mem_ack_in;
    logic [XLEN-1:0]   mem_rdata_in;

    modport master (
        input  i_req_in, i_addr_in,
        input  d_req_in, d_wr_in, d_addr_in, d_wdata_in, d_mask_in,
        input  mem_ack_in, mem_rdata_in,
        output i_ack_out, i_rdata_out, d_ack_out, d_rdata_out, err_out,
        output mem_req_out, mem_wr_out, mem_addr_out, mem_wdata_out, mem_mask_out
    );

    modport slave (
        output i_req_in, i_addr_in,
        output d_req_in, d_wr_in, d_addr_in, d_wdata_in, d_mask_in,
        output mem_ack_in, mem_rdata_in,
        input  i_ack_out, i_rdata_out, d_ack_out, d_rdata_out, err_out,
        input  mem_req_out, mem_wr_out, mem_addr_out, mem_wdata_out, mem_mask_out
    );

endinterface

// File: rtl/mem_port_arbiter_timeout.sv
// 16-bit transaction timeout counter; tc_out flags the last allowed cycle
// (count == TIMEOUT_CYC-1) while enabled. Usable by any bus master.
module arb_timeout_counter #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic clr_in,
    input  logic en_in,
    output logic tc_out
);

    localparam logic [15:0] TC_VAL = 16'(TIMEOUT_CYC - 1);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_in) begin
            cnt_d = '0;
        end else if (en_in) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_out = en_in && (cnt_q == TC_VAL);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and load/store,
// data first, with a bounded data streak and a per-transaction timeout.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC     = 255,
    parameter int unsigned MAX_DATA_STREAK = 4
) (
    input  logic                clk_in,
    input  logic                rst_in,
    mem_port_arbiter_if.master  bus
);

    localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);

    arb_state_e        state_q, state_d;
    logic [3:0]        streak_q, streak_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_wr_q, mem_wr_d;
    logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
    logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
    logic [MASK_W-1:0] mem_mask_q, mem_mask_d;
    logic              i_ack_q, i_ack_d;
    logic              d_ack_q, d_ack_d;
    logic [XLEN-1:0]   i_rdata_q, i_rdata_d;
    logic [XLEN-1:0]   d_rdata_q, d_rdata_d;
    logic              err_q, err_d;

    logic              grant_d, grant_i;
    logic              busy;
    logic              tmo_tc;
    logic              done;
    logic [XLEN-1:0]   rsp_data;

    arb_timeout_counter #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timeout (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .clr_in (state_q == IDLE),
        .en_in  (busy),
        .tc_out (tmo_tc)
    );

    always_comb begin
        busy    = (state_q == BUSY_I) || (state_q == BUSY_D);
        grant_d = bus.d_req_in && (!bus.i_req_in || (streak_q < STREAK_MAX));
        grant_i = bus.i_req_in && !grant_d;
        // A same-cycle ack beats the timeout.
        done    = busy && (bus.mem_ack_in || tmo_tc);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    state_d = BUSY_D;
                end else if (grant_i) begin
                    state_d = BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                if (done) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_req_d   = mem_req_q;
        mem_wr_d    = mem_wr_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_mask_d  = mem_mask_q;
        streak_d    = streak_q;
        i_ack_d     = 1'b0;
        d_ack_d     = 1'b0;
        i_rdata_d   = '0;
        d_rdata_d   = '0;
        err_d       = 1'b0;
        rsp_data    = '0;

        if (state_q == IDLE) begin
            if (grant_d) begin
                mem_req_d   = 1'b1;
                mem_wr_d    = bus.d_wr_in;
                mem_addr_d  = bus.d_addr_in;
                mem_wdata_d = bus.d_wdata_in;
                mem_mask_d  = bus.d_wr_in ? bus.d_mask_in : MASK_ALL;
                if (!bus.i_req_in) begin
                    streak_d = '0;
                end else if (streak_q < STREAK_MAX) begin
                    streak_d = streak_q + 4'd1;
                end
            end else if (grant_i) begin
                mem_req_d   = 1'b1;
                mem_wr_d    = 1'b0;
                mem_addr_d  = bus.i_addr_in;
                mem_wdata_d = '0;
                mem_mask_d  = MASK_ALL;
                streak_d    = '0;
            end
        end

        if (done) begin
            mem_req_d = 1'b0;
            mem_wr_d  = 1'b0;
            err_d     = !bus.mem_ack_in;
            rsp_data  = (bus.mem_ack_in && !mem_wr_q) ? bus.mem_rdata_in : '0;
            if (state_q == BUSY_I) begin
                i_ack_d   = 1'b1;
                i_rdata_d = rsp_data;
            end else begin
                d_ack_d   = 1'b1;
                d_rdata_d = rsp_data;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            streak_q    <= '0;
            mem_req_q   <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_mask_q  <= '0;
            i_ack_q     <= 1'b0;
            d_ack_q     <= 1'b0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            streak_q    <= streak_d;
            mem_req_q   <= mem_req_d;
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_mask_q  <= mem_mask_d;
            i_ack_q     <= i_ack_d;
            d_ack_q     <= d_ack_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
            err_q       <= err_d;
        end
    end

    assign bus.mem_req_out   = mem_req_q;
    assign bus.mem_wr_out    = mem_wr_q;
    assign bus.mem_addr_out  = mem_addr_q;
    assign bus.mem_wdata_out = mem_wdata_q;
    assign bus.mem_mask_out  = mem_mask_q;
    assign bus.i_ack_out     = i_ack_q;
    assign bus.i_rdata_out   = i_rdata_q;
    assign bus.d_ack_out     = d_ack_q;
    assign bus.d_rdata_out   = d_rdata_q;
    assign bus.err_out       = err_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported memory between the core's instruction-fetch port and its load/store port.
- Sits between the core pipeline (fetch address, store unit, load unit) and the external memory.
- Data accesses have priority; a bounded-streak rule guarantees fetch progress.
- A per-transaction timeout converts a hung memory into an error response instead of a deadlock.

Parameters:
- TIMEOUT_CYC, 255: cycles in BUSY without mem_ack_in before abort; legal range 1..65535.
- MAX_DATA_STREAK, 4: consecutive data grants allowed while a fetch is pending; legal range 1..15.

Ports:
- clk_in  input  1  clock
- rst_in  input  1  synchronous active-high reset
- i_req_in  input  1  fetch request; held until i_ack_out
- i_addr_in  input  32  fetch address
- i_ack_out  output  1  one-cycle fetch completion pulse
- i_rdata_out  output  32  fetch data, valid with i_ack_out
- d_req_in  input  1  data request; held until d_ack_out
- d_wr_in  input  1  1 = store, 0 = load
- d_addr_in  input  32  data address
- d_wdata_in  input  32  store data
- d_mask_in  input  4  store byte mask
- d_ack_out  output  1  one-cycle data completion pulse
- d_rdata_out  output  32  load data, valid with d_ack_out; 0 for stores
- err_out  output  1  asserted with either ack when the transaction timed out
- mem_req_out  output  1  memory request
- mem_wr_out  output  1  memory write strobe
- mem_addr_out  output  32  memory address
- mem_wdata_out  output  32  memory write data
- mem_mask_out  output  4  byte mask (4'hF for fetches and loads)
- mem_ack_in  input  1  memory completion, one cycle
- mem_rdata_in  input  32  memory read data, valid with mem_ack_in

Behaviour:
- One clock (clk_in). Reset is synchronous and active-high (rst_in): state goes to IDLE, all outputs are 0, all counters are 0.
- Reset mid-transaction drops mem_req_out on the next edge. The pending requester receives no ack.
- States: IDLE, BUSY_I, BUSY_D, RESP. All outputs are registered.
- IDLE:
  - d_req only: grant data.
  - i_req only: grant fetch.
  - Both, streak < MAX_DATA_STREAK: grant data.
  - Both, streak == MAX_DATA_STREAK: grant fetch.
  - On grant: latch address, wr, wdata and mask into the mem_*_out registers; set mem_req_out=1; clear the timeout counter; go to BUSY_I or BUSY_D.
- Streak counter:
  - Increments on a data grant while i_req_in=1.
  - Clears on any fetch grant, and on a data grant with i_req_in=0.
  - Saturates at MAX_DATA_STREAK.
- BUSY_x, mem_ack_in=1:
  - Capture mem_rdata_in (for a store, capture 0 instead).
  - Drop mem_req_out and mem_wr_out; go to RESP with err=0.
- BUSY_x, no ack: the timeout counter increments. When it equals TIMEOUT_CYC-1 and mem_ack_in=0:
  - Drop mem_req_out; rdata=0; err=1; go to RESP.
  - An ack arriving in the same cycle as the timeout wins, and no error is reported.
- RESP:
  - Pulse the granted requester's ack for exactly one cycle, with rdata and err_out.
  - Then go to IDLE unconditionally.
  - mem_ack_in is ignored in RESP and IDLE, so late acks after an abort are discarded.
- Requester contract: the requester deasserts req the cycle after seeing ack. Because RESP→IDLE takes a full cycle, a just-served request is never re-granted.
- Minimum latency: req sampled in IDLE at cycle 0; mem_req_out=1 at cycle 1; mem_ack_in at cycle 1; ack_out at cycle 2; IDLE at cycle 3. Back-to-back throughput is one transaction per 3 cycles.
- mem_req_out stays high and its payload stays stable for the whole of BUSY.
- The payload is latched, so requester input changes during BUSY have no effect.
- err_out is 0 except in the RESP cycle of a timed-out transaction.

Decomposition:
- Shared package holds:
  - state encoding constants: IDLE=2'd0, BUSY_I=2'd1, BUSY_D=2'd2, RESP=2'd3
  - MASK_ALL=4'hF
  - widths XLEN=32, MASK_W=4
- One natural sub-module, arb_timeout_counter: clear, enable, terminal-count pulse at TIMEOUT_CYC-1, 16-bit. It is reusable by other bus masters.
- Grant logic and the streak counter stay in the top module.

Test Plan:
- Fetch only: i_req=1, i_addr=32'h100, mem_ack at cycle 1 with rdata 32'h00000013.
  - mem_addr_out=32'h100, mem_mask_out=4'hF.
  - i_ack_out at cycle 2 with i_rdata_out=32'h13; d_ack_out stays 0.
- Store: d_req=1, d_wr=1, d_addr=32'h2004, d_wdata=32'hDEADBEEF, d_mask=4'b1100, mem ack after 3 cycles.
  - mem_wr_out=1 with the latched payload.
  - d_ack_out pulses once with d_rdata_out=0.
- Contention:
  - Setup: i_req and d_req both held high; the data requester re-requests immediately after each ack; MAX_DATA_STREAK=4.
  - Grant order: D,D,D,D,I,D,...
  - The streak clears after the I grant.
- Timeout: TIMEOUT_CYC=8, mem_ack never arrives.
  - mem_req_out high for exactly 8 cycles.
  - Requester ack with err_out=1 and rdata=0.
  - A late mem_ack_in 2 cycles later is ignored.
- Ack on the timeout cycle: mem_ack_in arrives exactly on cycle TIMEOUT_CYC-1 → normal ack, err_out=0, rdata captured.
- Reset in BUSY_D: rst_in high for 1 cycle → next cycle mem_req_out=0 and all outputs 0; no d_ack_out; a new request is serviced normally afterwards.
